// File: rtl/mem_readback_checker.sv
// Read-back self-check for the three-RAM memory test: compares each sampled
// A/B/C word against the incrementing write pattern and reports a pass flag.
module mem_readback_checker #(
    parameter int unsigned N_SAMPLES = 7,
    parameter logic [31:0] EXP_START = 32'd0,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             sample_en,
    input  logic [31:0]      mem_a,
    input  logic [31:0]      mem_b,
    input  logic [7:0]       mem_c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [31:0]      checksum
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] idx;
    logic [31:0]      exp_val;

    logic             accept;
    logic             take;
    logic             mismatch;
    logic [CNT_W-1:0] err_nxt;
    logic [31:0]      sum_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus per-sample compare; abort overrides everything
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        take       = 1'b0;
        mismatch   = (mem_a != exp_val) || (mem_b != exp_val) ||
                     (mem_c != exp_val[7:0]);
        err_nxt    = err_cnt;
        sum_nxt    = checksum + mem_a + mem_b + {24'b0, mem_c};

        if (mismatch && (err_cnt != ALL_ONES)) begin
            err_nxt = err_cnt + CNT_W'(1);
        end

        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        next_state = S_RUN;
                        accept     = 1'b1;
                    end
                end
                S_RUN: begin
                    if (sample_en) begin
                        take = 1'b1;
                        if (idx == LAST_IDX) begin
                            next_state = S_DONE;
                        end
                    end
                end
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= ALL_ONES;
            checksum      <= 32'd0;
            idx           <= '0;
            exp_val       <= EXP_START;
        end else begin
            busy <= (next_state == S_RUN);
            done <= (next_state == S_DONE);

            if (abort) begin
                pass <= 1'b0;
            end else if (accept) begin
                pass          <= 1'b0;
                err_cnt       <= '0;
                first_err_idx <= ALL_ONES;
                checksum      <= 32'd0;
                idx           <= '0;
                exp_val       <= EXP_START;
            end else if (take) begin
                err_cnt  <= err_nxt;
                checksum <= sum_nxt;
                exp_val  <= exp_val + 32'd1;
                idx      <= idx + CNT_W'(1);
                if (mismatch && (first_err_idx == ALL_ONES)) begin
                    first_err_idx <= idx;
                end
                // pass must already be valid during the done cycle
                if (next_state == S_DONE) begin
                    pass <= (err_nxt == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_readback_checker.sv
// Directed bench for mem_readback_checker: a small reference model pushes the
// expected run results to a scoreboard that is popped on each done pulse.
module tb_mem_readback_checker;

    typedef struct packed {
        logic        pass;
        logic [9:0]  err;
        logic [9:0]  first;
        logic [31:0] sum;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_s, abort, abort_s, sample_en;
    logic [31:0] mem_a, mem_b;
    logic [7:0]  mem_c;

    logic        busy, done, pass;
    logic [9:0]  err_cnt, first_err_idx;
    logic [31:0] checksum;
    logic        busy_s, done_s, pass_s;
    logic [9:0]  err_cnt_s, first_err_idx_s;
    logic [31:0] checksum_s;

    int n_tests = 0;
    int n_fail  = 0;

    res_t sb[$];
    int   m_n, m_idx;
    logic [31:0] m_exp, m_sum;
    logic [9:0]  m_err, m_first;

    logic        sel;
    logic        o_busy, o_done, o_pass;
    logic [9:0]  o_err, o_first;
    logic [31:0] o_sum;

    always #5 clk = ~clk;

    mem_readback_checker dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sample_en(sample_en), .mem_a(mem_a), .mem_b(mem_b), .mem_c(mem_c),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .checksum(checksum)
    );

    mem_readback_checker #(.N_SAMPLES(1023), .EXP_START(32'd0), .CNT_W(10)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
        .sample_en(sample_en), .mem_a(mem_a), .mem_b(mem_b), .mem_c(mem_c),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s),
        .first_err_idx(first_err_idx_s), .checksum(checksum_s)
    );

    always_comb begin
        o_busy  = sel ? busy_s          : busy;
        o_done  = sel ? done_s          : done;
        o_pass  = sel ? pass_s          : pass;
        o_err   = sel ? err_cnt_s       : err_cnt;
        o_first = sel ? first_err_idx_s : first_err_idx;
        o_sum   = sel ? checksum_s      : checksum;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arms the selected DUT and the model; returns at the negedge after acceptance
    task automatic start_run(input logic which, input int n);
        sel = which;
        if (which) start_s = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_s = 1'b0;
        m_n = n; m_idx = 0; m_exp = 32'd0; m_err = 10'd0; m_first = 10'h3FF; m_sum = 32'd0;
        check("busy_after_start", {31'd0, o_busy}, 32'd1);
    endtask

    // Drives one accepted sample and advances the reference model
    task automatic sample(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
        logic bad;
        sample_en = 1'b1; mem_a = a; mem_b = b; mem_c = c;
        bad = (a != m_exp) || (b != m_exp) || (c != m_exp[7:0]);
        if (bad) begin
            if (m_err != 10'h3FF) m_err = m_err + 10'd1;
            if (m_first == 10'h3FF) m_first = 10'(m_idx);
        end
        m_sum = m_sum + a + b + {24'd0, c};
        m_exp = m_exp + 32'd1;
        m_idx++;
        if (m_idx == m_n) sb.push_back('{(m_err == 10'd0), m_err, m_first, m_sum});
        @(negedge clk);
    endtask

    task automatic gap();
        sample_en = 1'b0; mem_a = 32'hDEAD_BEEF; mem_b = 32'h0BAD_F00D; mem_c = 8'h5A;
        @(negedge clk);
    endtask

    // Bounded wait for done; expected latency is in cycles past the current negedge
    task automatic wait_done(input string tag, input int lat);
        int   k;
        res_t e;
        sample_en = 1'b0;
        for (k = 0; k < 2000; k++) begin
            if (o_done) break;
            @(negedge clk);
        end
        check({tag, "_done_seen"}, {31'd0, o_done}, 32'd1);
        check({tag, "_done_latency"}, k, lat);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_pass"},  {31'd0, o_pass}, {31'd0, e.pass});
            check({tag, "_err"},   {22'd0, o_err},  {22'd0, e.err});
            check({tag, "_first"}, {22'd0, o_first}, {22'd0, e.first});
            check({tag, "_sum"},   o_sum, e.sum);
            check({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
        check({tag, "_pass_held"}, {31'd0, o_pass}, {31'd0, e.pass});
    endtask

    initial begin
        logic saw;
        rst = 1'b1; start = 1'b0; start_s = 1'b0; abort = 1'b0; abort_s = 1'b0;
        sample_en = 1'b0; mem_a = 32'd0; mem_b = 32'd0; mem_c = 8'd0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_pass",  {31'd0, pass}, 32'd0);
        check("rst_err",   {22'd0, err_cnt}, 32'd0);
        check("rst_first", {22'd0, first_err_idx}, 32'h3FF);
        check("rst_sum",   checksum, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Clean run
        start_run(1'b0, 7);
        for (int i = 0; i < 7; i++) sample(32'(i), 32'(i), 8'(i));
        wait_done("clean", 0);
        check("clean_sum_const", checksum, 32'h3F);

        // Single corruption in lane B
        start_run(1'b0, 7);
        for (int i = 0; i < 7; i++) sample(32'(i), (i == 3) ? 32'h5 : 32'(i), 8'(i));
        wait_done("single", 0);
        check("single_sum_const", checksum, 32'h41);

        // Multi-lane mismatch with gaps between samples
        start_run(1'b0, 7);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) sample(32'hFFFF_0000, 32'h1234_5678, 8'hAA);
            else        sample(32'(i), 32'(i), 8'(i));
            if (i == 5) check("gaps_no_early_done", {31'd0, done}, 32'd0);
            if (i < 6) gap();
        end
        wait_done("gaps", 0);
        check("gaps_err_const", {22'd0, err_cnt}, 32'd1);

        // Ignored start in RUN, then abort at sample 4
        start_run(1'b0, 7);
        sample(32'd0, 32'd0, 8'd0);
        sample(32'd1, 32'd9, 8'd1);
        start = 1'b1;
        sample(32'd2, 32'd2, 8'd2);
        start = 1'b0;
        sample(32'd3, 32'd3, 8'd3);
        abort = 1'b1; sample_en = 1'b1; mem_a = 32'd4; mem_b = 32'd4; mem_c = 8'd4;
        @(negedge clk);
        abort = 1'b0; sample_en = 1'b0;
        check("abort_busy",  {31'd0, busy}, 32'd0);
        check("abort_done",  {31'd0, done}, 32'd0);
        check("abort_pass",  {31'd0, pass}, 32'd0);
        check("abort_err",   {22'd0, err_cnt}, {22'd0, m_err});
        check("abort_first", {22'd0, first_err_idx}, {22'd0, m_first});
        check("abort_sum",   checksum, m_sum);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) saw = 1'b1;
            if (i == 5) begin sample_en = 1'b1; mem_a = 32'd4; mem_b = 32'd4; mem_c = 8'd4; end
            @(negedge clk);
        end
        sample_en = 1'b0;
        check("abort_no_done", {31'd0, saw}, 32'd0);
        check("abort_err_frozen", {22'd0, err_cnt}, {22'd0, m_err});

        // abort and start together in IDLE
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", {31'd0, busy}, 32'd0);

        // Async reset between edges after sample 2
        start_run(1'b0, 7);
        sample(32'd0, 32'd0, 8'd0);
        sample(32'd1, 32'd1, 8'd7);
        sample(32'd2, 32'd2, 8'd2);
        sample_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_busy",  {31'd0, busy}, 32'd0);
        check("arst_done",  {31'd0, done}, 32'd0);
        check("arst_pass",  {31'd0, pass}, 32'd0);
        check("arst_err",   {22'd0, err_cnt}, 32'd0);
        check("arst_first", {22'd0, first_err_idx}, 32'h3FF);
        check("arst_sum",   checksum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_run(1'b0, 7);
        for (int i = 0; i < 7; i++) sample(32'(i), 32'(i), 8'(i));
        wait_done("post_rst", 0);
        check("post_rst_sum_const", checksum, 32'h3F);

        // Saturation on the 1023-sample instance: every sample wrong
        start_run(1'b1, 1023);
        for (int i = 0; i < 1023; i++) sample(~32'(i), 32'(i), 8'(i));
        wait_done("sat", 0);
        check("sat_err_const",   {22'd0, err_cnt_s}, 32'h3FF);
        check("sat_first_const", {22'd0, first_err_idx_s}, 32'd0);
        check("sat_other_idle",  {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
